// File: rtl/axis_frame_arbiter_if.sv
// Bundle of every stream and status signal of axis_frame_arbiter.
//  master : arbiter side. Drives s_axis_ready, eng_s_*, eng_m_ready, m_axis_valid/data/id,
//           busy, proto_err and state_dbg.
//  slave  : environment side (requester sources, compute engine, downstream sink).
//  Requester k owns s_axis_data[k*DATA_WIDTH +: DATA_WIDTH].
//  state_dbg mirrors the arbiter FSM (0 IDLE, 1 FILL, 2 DRAIN).
// Instantiate this with the same DATA_WIDTH / N_SRC as the arbiter.
interface axis_frame_arbiter_if #(
  parameter int DATA_WIDTH = 32,
  parameter int N_SRC      = 4
);
  localparam int ID_WIDTH = (N_SRC > 1) ? $clog2(N_SRC) : 1;

  logic [N_SRC-1:0]            s_axis_valid;
  logic [N_SRC*DATA_WIDTH-1:0] s_axis_data;
  logic [N_SRC-1:0]            s_axis_ready;
  logic                        eng_s_valid;
  logic [DATA_WIDTH-1:0]       eng_s_data;
  logic                        eng_s_ready;
  logic                        eng_m_valid;
  logic [DATA_WIDTH-1:0]       eng_m_data;
  logic                        eng_m_ready;
  logic                        m_axis_valid;
  logic [DATA_WIDTH-1:0]       m_axis_data;
  logic [ID_WIDTH-1:0]         m_axis_id;
  logic                        m_axis_ready;
  logic                        busy;
  logic                        proto_err;
  logic [1:0]                  state_dbg;

  modport master (
    input  s_axis_valid, s_axis_data, eng_s_ready, eng_m_valid, eng_m_data, m_axis_ready,
    output s_axis_ready, eng_s_valid, eng_s_data, eng_m_ready,
    output m_axis_valid, m_axis_data, m_axis_id, busy, proto_err, state_dbg
  );

  modport slave (
    output s_axis_valid, s_axis_data, eng_s_ready, eng_m_valid, eng_m_data, m_axis_ready,
    input  s_axis_ready, eng_s_valid, eng_s_data, eng_m_ready,
    input  m_axis_valid, m_axis_data, m_axis_id, busy, proto_err, state_dbg
  );
endinterface

// File: rtl/axis_frame_arbiter.sv
// axis_frame_arbiter: shares one frame-based stream engine between N_SRC requesters.
// One requester is granted per frame (round-robin after the previously served one),
// FRAME_LEN beats are passed through to the engine, then FRAME_LEN result beats are
// passed back out on m_axis tagged with the requester id.
// Ports:
//  axi_clk      clock, rising edge
//  axi_reset_n  asynchronous active-low reset (engine shares it)
//  bus          axis_frame_arbiter_if.master: requester streams, engine in/out streams,
//               shared result stream, busy / proto_err status, state_dbg
// Handshake: a beat transfers on a rising edge where valid && ready are both 1. Valid never
// waits on ready; ready/valid here are pure muxes of the peer's signals, so holding data
// stable while valid && !ready stays the producer's duty and is preserved end to end.
module axis_frame_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int N_SRC      = 4,
  parameter int FRAME_LEN  = 8
) (
  input  logic                 axi_clk,
  input  logic                 axi_reset_n,
  axis_frame_arbiter_if.master bus
);
  localparam int ID_WIDTH  = (N_SRC > 1) ? $clog2(N_SRC) : 1;
  localparam int CNT_WIDTH = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [CNT_WIDTH-1:0] LAST_BEAT = CNT_WIDTH'(FRAME_LEN - 1);
  localparam logic [ID_WIDTH-1:0]  LAST_SRC  = ID_WIDTH'(N_SRC - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, FILL = 2'd1, DRAIN = 2'd2} state_t;

  state_t                state, state_nxt;
  logic [ID_WIDTH-1:0]   grant, grant_nxt;
  logic [ID_WIDTH-1:0]   last_grant, last_grant_nxt;
  logic [CNT_WIDTH-1:0]  beat_cnt, beat_cnt_nxt;
  logic                  proto_err_q;

  logic                  any_req;
  logic [ID_WIDTH-1:0]   arb_pick;
  logic [ID_WIDTH-1:0]   cand;
  logic [DATA_WIDTH-1:0] src_word [N_SRC];
  logic                  in_fire, out_fire;

  // Round-robin search starting just after last_grant; last_grant itself is tried last.
  always_comb begin
    any_req  = 1'b0;
    arb_pick = last_grant;
    cand     = '0;
    for (int i = 1; i <= N_SRC; i++) begin
      cand = ID_WIDTH'((int'(last_grant) + i) % N_SRC);
      if (!any_req && bus.s_axis_valid[cand]) begin
        any_req  = 1'b1;
        arb_pick = cand;
      end
    end
  end

  always_comb begin
    for (int k = 0; k < N_SRC; k++) begin
      src_word[k] = bus.s_axis_data[k*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // eng_s_valid / m_axis_valid are only non-zero in FILL / DRAIN respectively.
  assign in_fire  = bus.eng_s_valid  && bus.eng_s_ready;
  assign out_fire = bus.m_axis_valid && bus.m_axis_ready;

  // State register
  always_ff @(posedge axi_clk or negedge axi_reset_n) begin
    if (!axi_reset_n) begin
      state       <= IDLE;
      grant       <= '0;
      last_grant  <= LAST_SRC;
      beat_cnt    <= '0;
      proto_err_q <= 1'b0;
    end else begin
      state      <= state_nxt;
      grant      <= grant_nxt;
      last_grant <= last_grant_nxt;
      beat_cnt   <= beat_cnt_nxt;
      // The engine may only present results while we drain it.
      if (bus.eng_m_valid && (state != DRAIN)) begin
        proto_err_q <= 1'b1;
      end
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt      = state;
    grant_nxt      = grant;
    last_grant_nxt = last_grant;
    beat_cnt_nxt   = beat_cnt;
    case (state)
      IDLE: begin
        if (any_req) begin
          grant_nxt    = arb_pick;
          beat_cnt_nxt = '0;
          state_nxt    = FILL;
        end
      end
      FILL: begin
        // A stalled granted source keeps the frame locked; there is no timeout.
        if (in_fire) begin
          if (beat_cnt == LAST_BEAT) begin
            beat_cnt_nxt = '0;
            state_nxt    = DRAIN;
          end else begin
            beat_cnt_nxt = beat_cnt + 1'b1;
          end
        end
      end
      DRAIN: begin
        if (out_fire) begin
          if (beat_cnt == LAST_BEAT) begin
            beat_cnt_nxt   = '0;
            last_grant_nxt = grant;
            state_nxt      = IDLE;
          end else begin
            beat_cnt_nxt = beat_cnt + 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic: zero-latency muxes selected by state and grant.
  always_comb begin
    bus.s_axis_ready = '0;
    bus.eng_s_valid  = 1'b0;
    bus.eng_s_data   = src_word[grant];
    bus.eng_m_ready  = 1'b0;
    bus.m_axis_valid = 1'b0;
    bus.m_axis_data  = bus.eng_m_data;
    bus.m_axis_id    = grant;
    case (state)
      FILL: begin
        bus.eng_s_valid         = bus.s_axis_valid[grant];
        bus.s_axis_ready[grant] = bus.eng_s_ready;
      end
      DRAIN: begin
        bus.m_axis_valid = bus.eng_m_valid;
        bus.eng_m_ready  = bus.m_axis_ready;
      end
      default: ;
    endcase
  end

  assign bus.busy      = (state != IDLE);
  assign bus.proto_err = proto_err_q;
  assign bus.state_dbg = state;
endmodule

// File: tb/tb_axis_frame_arbiter.sv
// Bench for axis_frame_arbiter: behavioural requester sources, a FRAME_LEN-deep engine
// that returns (input - 1) per beat, and a result monitor fed by an expected queue.
module tb_axis_frame_arbiter;
  localparam int DW = 32;
  localparam int NS = 4;
  localparam int FL = 8;
  localparam int EW = 2 + DW;  // {id, data}

  // ---------------- clock / reset ----------------
  logic axi_clk     = 1'b0;
  logic axi_reset_n = 1'b0;
  int   cyc         = 0;

  initial forever #5 axi_clk = ~axi_clk;
  always @(posedge axi_clk) cyc <= cyc + 1;

  axis_frame_arbiter_if #(.DATA_WIDTH(DW), .N_SRC(NS)) bus ();

  axis_frame_arbiter #(.DATA_WIDTH(DW), .N_SRC(NS), .FRAME_LEN(FL)) dut (
    .axi_clk     (axi_clk),
    .axi_reset_n (axi_reset_n),
    .bus         (bus)
  );

  // ---------------- scoreboard state ----------------
  logic [EW-1:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;
  int out_cnt  = 0;
  bit t3_watch = 1'b0;
  bit low_ready_seen = 1'b0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
  endtask

  // ---------------- source / engine models ----------------
  int            src_left  [NS] = '{default: 0};
  logic [DW-1:0] src_data  [NS] = '{default: '0};
  int            src_fires [NS] = '{default: 0};
  logic [DW-1:0] eng_buf   [FL];
  int            eng_in_cnt  = 0;
  int            eng_out_idx = 0;
  int            eng_in_fires = 0;
  bit            eng_full  = 1'b0;
  bit            eng_stall = 1'b0;
  bit            force_mv  = 1'b0;
  bit            rand_bp   = 1'b0;

  task automatic drive();
    for (int k = 0; k < NS; k++) begin
      bus.s_axis_valid[k]           = (src_left[k] != 0);
      bus.s_axis_data[k*DW +: DW]   = src_data[k];
    end
    bus.eng_s_ready  = !eng_full && !eng_stall && (!rand_bp || ($urandom_range(0, 1) == 1));
    bus.eng_m_valid  = eng_full || force_mv;
    bus.eng_m_data   = eng_full ? (eng_buf[eng_out_idx] - 32'd1) : 32'hDEADBEEF;
    bus.m_axis_ready = !rand_bp || ($urandom_range(0, 1) == 1);
  endtask

  // Samples handshakes mid-cycle, advances models just after the rising edge.
  initial begin : driver
    logic [NS-1:0] s_fire;
    logic          e_in, e_out;
    logic [DW-1:0] e_in_data;
    drive();
    forever begin
      @(negedge axi_clk);
      s_fire    = bus.s_axis_valid & bus.s_axis_ready;
      e_in      = bus.eng_s_valid & bus.eng_s_ready;
      e_in_data = bus.eng_s_data;
      e_out     = bus.eng_m_valid & bus.eng_m_ready;
      @(posedge axi_clk);
      #1;
      if (!axi_reset_n) begin
        for (int k = 0; k < NS; k++) src_left[k] = 0;
        eng_full = 1'b0; eng_in_cnt = 0; eng_out_idx = 0;
      end else begin
        for (int k = 0; k < NS; k++) begin
          if (s_fire[k]) begin
            src_left[k]--; src_data[k]++; src_fires[k]++;
          end
        end
        if (e_in && !eng_full) begin
          eng_buf[eng_in_cnt] = e_in_data;
          eng_in_cnt++; eng_in_fires++;
          if (eng_in_cnt == FL) begin eng_full = 1'b1; eng_out_idx = 0; end
        end
        if (e_out && eng_full) begin
          eng_out_idx++;
          if (eng_out_idx == FL) begin eng_full = 1'b0; eng_out_idx = 0; eng_in_cnt = 0; end
        end
      end
      drive();
    end
  end

  // ---------------- monitor ----------------
  logic [EW-1:0] mon_got, mon_exp;
  always @(negedge axi_clk) begin
    if (t3_watch && (bus.s_axis_ready[1:0] != 2'b00)) low_ready_seen = 1'b1;
    if (axi_reset_n && bus.m_axis_valid && bus.m_axis_ready) begin
      mon_got = {bus.m_axis_id, bus.m_axis_data};
      if (exp_q.size() == 0) begin
        check("m_axis unexpected beat", 64'(mon_got), 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        mon_exp = exp_q.pop_front();
        check("m_axis beat {id,data}", 64'(mon_got), 64'(mon_exp));
      end
      out_cnt++;
    end
  end

  // ---------------- helpers ----------------
  task automatic tick();
    @(negedge axi_clk);
    #1;
  endtask

  task automatic do_reset();
    axi_reset_n = 1'b0;
    repeat (3) tick();
    axi_reset_n = 1'b1;
    tick();
  endtask

  task automatic start_src(input int k, input int n, input logic [DW-1:0] base);
    src_left[k] = n;
    src_data[k] = base;
  endtask

  task automatic push_frame(input logic [1:0] id, input logic [DW-1:0] base);
    for (int j = 0; j < FL; j++) exp_q.push_back({id, base + DW'(j) - 32'd1});
  endtask

  task automatic wait_done(input string name, input int budget);
    bit done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      tick();
      done = (exp_q.size() == 0) && !bus.busy;
      for (int k = 0; k < NS; k++) if (src_left[k] != 0) done = 1'b0;
    end
    check(name, 64'(done), 64'd1);
  endtask

  task automatic check_quiet(input string tag);
    check({tag, " busy"},         64'(bus.busy),         64'd0);
    check({tag, " state"},        64'(bus.state_dbg),    64'd0);
    check({tag, " s_axis_ready"}, 64'(bus.s_axis_ready), 64'd0);
    check({tag, " eng_s_valid"},  64'(bus.eng_s_valid),  64'd0);
    check({tag, " eng_m_ready"},  64'(bus.eng_m_ready),  64'd0);
    check({tag, " m_axis_valid"}, 64'(bus.m_axis_valid), 64'd0);
    check({tag, " m_axis_id"},    64'(bus.m_axis_id),    64'd0);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin : main
    int base_out, s1, s3, e0, nrise, pb;
    int rise_cyc [5];
    bit ok;

    // Reset values
    tick(); tick();
    check_quiet("reset");
    check("reset proto_err", 64'(bus.proto_err), 64'd0);
    axi_reset_n = 1'b1;
    tick();

    // 1: single source, data-1 returned with id 0
    base_out = out_cnt;
    push_frame(2'd0, 32'h10);
    start_src(0, 8, 32'h10);
    wait_done("t1 frame done", 100);
    check("t1 beats out", 64'(out_cnt - base_out), 64'd8);
    check("t1 busy after", 64'(bus.busy), 64'd0);

    // 2: all sources valid, round-robin 0,1,2,3,0 with 17-cycle frames
    do_reset();
    push_frame(2'd0, 32'h1000); push_frame(2'd1, 32'h2000);
    push_frame(2'd2, 32'h3000); push_frame(2'd3, 32'h4000);
    push_frame(2'd0, 32'h1008);
    start_src(0, 16, 32'h1000); start_src(1, 8, 32'h2000);
    start_src(2, 8, 32'h3000);  start_src(3, 8, 32'h4000);
    nrise = 0; pb = 0;
    for (int i = 0; i < 200 && nrise < 5; i++) begin
      tick();
      if (bus.busy && pb == 0) begin rise_cyc[nrise] = cyc; nrise++; end
      pb = int'(bus.busy);
    end
    check("t2 frame starts seen", 64'(nrise), 64'd5);
    for (int i = 1; i < 5; i++)
      if (i < nrise) check("t2 frame period", 64'(rise_cyc[i] - rise_cyc[i-1]), 64'd17);
    wait_done("t2 frames done", 200);

    // 3: last_grant=2, then src2+src3 contend -> 3 before 2
    push_frame(2'd2, 32'h5000);
    start_src(2, 8, 32'h5000);
    wait_done("t3 prep done", 100);
    t3_watch = 1'b1;
    push_frame(2'd3, 32'h6000); push_frame(2'd2, 32'h7000);
    start_src(2, 8, 32'h7000); start_src(3, 8, 32'h6000);
    wait_done("t3 frames done", 200);
    t3_watch = 1'b0;
    check("t3 src0/1 ready seen", 64'(low_ready_seen), 64'd0);

    // 4: 50% backpressure both directions; last_grant=2 -> src3 then src1
    rand_bp = 1'b1;
    base_out = out_cnt; s1 = src_fires[1]; s3 = src_fires[3]; e0 = eng_in_fires;
    push_frame(2'd3, 32'h8000); push_frame(2'd1, 32'h9000);
    start_src(1, 8, 32'h9000); start_src(3, 8, 32'h8000);
    wait_done("t4 frames done", 600);
    rand_bp = 1'b0;
    check("t4 src3 beats", 64'(src_fires[3] - s3), 64'd8);
    check("t4 src1 beats", 64'(src_fires[1] - s1), 64'd8);
    check("t4 engine beats in", 64'(eng_in_fires - e0), 64'd16);
    check("t4 result beats out", 64'(out_cnt - base_out), 64'd16);

    // 5: engine result valid during FILL
    eng_stall = 1'b1;
    push_frame(2'd0, 32'hA000);
    start_src(0, 8, 32'hA000);
    ok = 1'b0;
    for (int i = 0; i < 10 && !ok; i++) begin tick(); ok = bus.busy; end
    check("t5 entered FILL", 64'(ok), 64'd1);
    force_mv = 1'b1;
    tick(); tick();
    check("t5 state FILL",    64'(bus.state_dbg),    64'd1);
    check("t5 proto_err set", 64'(bus.proto_err),    64'd1);
    check("t5 eng_m_ready",   64'(bus.eng_m_ready),  64'd0);
    check("t5 m_axis_valid",  64'(bus.m_axis_valid), 64'd0);
    force_mv = 1'b0; eng_stall = 1'b0;
    wait_done("t5 frame done", 100);
    check("t5 proto_err sticky", 64'(bus.proto_err), 64'd1);
    do_reset();
    check("t5 proto_err cleared", 64'(bus.proto_err), 64'd0);

    // 6: reset at DRAIN beat 3, then src0 wins over src2
    base_out = out_cnt;
    for (int j = 0; j < 3; j++) exp_q.push_back({2'd1, 32'hB000 + DW'(j) - 32'd1});
    start_src(1, 8, 32'hB000);
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(posedge axi_clk); #2;
      ok = (out_cnt - base_out) == 3;
    end
    check("t6 reached drain beat 3", 64'(ok), 64'd1);
    axi_reset_n = 1'b0;
    #1;
    check_quiet("t6 in reset");
    repeat (3) tick();
    check("t6 beats before reset", 64'(out_cnt - base_out), 64'd3);
    axi_reset_n = 1'b1;
    tick();
    push_frame(2'd0, 32'hC000); push_frame(2'd2, 32'hD000);
    start_src(0, 8, 32'hC000); start_src(2, 8, 32'hD000);
    wait_done("t6 frames done", 200);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
